// File: rtl/axi_apb_xfer_engine.sv
// axi_apb_xfer_engine: pops one AXI_to_APB queue entry (plus write data for
// writes), runs a single APB SETUP/ACCESS transfer and returns a response.
// Ports:
//   clk, rst (sync, active-high)
//   addr_*   address queue entry (valid/ready, awaddr, araddr, rw, id)
//   wdat_*   write-data queue entry (valid/ready, data, id, last)
//   p*       APB requester (psel, penable, pwrite, paddr, pwdata, pready,
//            prdata, pslverr)
//   rsp_*    response entry (valid/ready, id, rw, rdata, resp)
module axi_apb_xfer_engine #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     addr_valid,
    output logic                     addr_ready,
    input  logic [ADDRESS_WIDTH-1:0] addr_awaddr,
    input  logic [ADDRESS_WIDTH-1:0] addr_araddr,
    input  logic                     addr_rw,
    input  logic [3:0]               addr_id,
    input  logic                     wdat_valid,
    output logic                     wdat_ready,
    input  logic [DATA_WIDTH-1:0]    wdat_data,
    input  logic [3:0]               wdat_id,
    input  logic                     wdat_last,
    output logic                     psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [ADDRESS_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0]    pwdata,
    input  logic                     pready,
    input  logic [DATA_WIDTH-1:0]    prdata,
    input  logic                     pslverr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [3:0]               rsp_id,
    output logic                     rsp_rw,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit T_EN = (TIMEOUT_CYCLES != 0);
    // Last count value before the abort fires: the abort happens at the end
    // of the TIMEOUT_CYCLES-th stalled ACCESS cycle.
    localparam logic [TW-1:0] T_LAST =
        TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] tcount;
    logic          bad_write;

    // Both entries pop together; a read never touches the data queue.
    assign addr_ready = (state == IDLE) & addr_valid & (~addr_rw | wdat_valid);
    assign wdat_ready = (state == IDLE) & addr_valid & addr_rw & wdat_valid;

    assign bad_write = addr_rw & ((wdat_id != addr_id) | ~wdat_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tcount    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rw    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
        end else begin
            unique case (state)
                IDLE: begin
                    if (addr_ready) begin
                        pwrite    <= addr_rw;
                        paddr     <= addr_rw ? addr_awaddr : addr_araddr;
                        pwdata    <= addr_rw ? wdat_data : '0;
                        rsp_id    <= addr_id;
                        rsp_rw    <= addr_rw;
                        rsp_rdata <= '0;
                        if (bad_write) begin
                            // Mismatched or non-final beat: fail without
                            // touching the bus.
                            rsp_resp  <= RESP_SLVERR;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            rsp_resp <= RESP_OKAY;
                            psel     <= 1'b1;
                            state    <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_resp  <= pslverr ? RESP_SLVERR : RESP_OKAY;
                        rsp_rdata <= (pwrite | pslverr) ? '0 : prdata;
                        tcount    <= '0;
                        state     <= RESP;
                    end else if (T_EN && tcount == T_LAST) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_resp  <= RESP_SLVERR;
                        rsp_rdata <= '0;
                        tcount    <= '0;
                        state     <= RESP;
                    end else if (T_EN) begin
                        tcount <= tcount + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_apb_xfer_engine.sv
// tb_axi_apb_xfer_engine: directed vector table plus hand sequences for
// timeout, backpressure and mid-transfer reset of axi_apb_xfer_engine.
module tb_axi_apb_xfer_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        addr_valid;
    logic        addr_ready;
    logic [31:0] addr_awaddr;
    logic [31:0] addr_araddr;
    logic        addr_rw;
    logic [3:0]  addr_id;
    logic        wdat_valid;
    logic        wdat_ready;
    logic [31:0] wdat_data;
    logic [3:0]  wdat_id;
    logic        wdat_last;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_id;
    logic        rsp_rw;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_apb_xfer_engine #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .addr_valid(addr_valid), .addr_ready(addr_ready),
        .addr_awaddr(addr_awaddr), .addr_araddr(addr_araddr),
        .addr_rw(addr_rw), .addr_id(addr_id),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready),
        .wdat_data(wdat_data), .wdat_id(wdat_id), .wdat_last(wdat_last),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_rw(rsp_rw),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp)
    );

    typedef struct {
        logic        rw;
        logic [31:0] awaddr;
        logic [31:0] araddr;
        logic [3:0]  id;
        logic [31:0] wdata;
        logic [3:0]  wid;
        logic        wlast;
        int          waits;
        logic [31:0] rdata_in;
        logic        slverr;
        logic        apb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        addr_valid = 0; addr_rw = 0; addr_id = 0;
        addr_awaddr = 0; addr_araddr = 0;
        wdat_valid = 0; wdat_data = 0; wdat_id = 0; wdat_last = 0;
        pready = 0; prdata = 0; pslverr = 0; rsp_ready = 0;
    endtask

    task automatic drive_req(input vec_t v);
        addr_valid  = 1;
        addr_rw     = v.rw;
        addr_awaddr = v.awaddr;
        addr_araddr = v.araddr;
        addr_id     = v.id;
        wdat_valid  = v.rw;
        wdat_data   = v.wdata;
        wdat_id     = v.wid;
        wdat_last   = v.wlast;
    endtask

    // Apply one table vector starting in IDLE, from pop through handshake.
    task automatic run_vec(input int k, input vec_t v);
        logic [31:0] ea;
        logic [31:0] ed;
        ea = v.rw ? v.awaddr : v.araddr;
        ed = v.rw ? v.wdata : 32'h0;
        drive_req(v);
        #1;
        chk($sformatf("v%0d addr_ready", k), addr_ready, 1);
        chk($sformatf("v%0d wdat_ready", k), wdat_ready, v.rw);
        step();
        idle_inputs();
        #1;
        if (v.apb) begin
            chk($sformatf("v%0d setup psel/pen", k), {psel, penable}, 2'b10);
            chk($sformatf("v%0d setup paddr", k), paddr, ea);
            step();
            for (int w = 0; w <= v.waits; w++) begin
                pready  = (w == v.waits);
                prdata  = v.rdata_in;
                pslverr = v.slverr;
                chk($sformatf("v%0d acc%0d psel/pen", k, w),
                    {psel, penable, rsp_valid}, 3'b110);
                chk($sformatf("v%0d acc%0d bus", k, w),
                    {pwrite, paddr, pwdata}, {v.rw, ea, ed});
                step();
            end
            pready = 0; pslverr = 0; prdata = 0;
        end
        chk($sformatf("v%0d rsp_valid/psel", k),
            {rsp_valid, psel, penable}, 3'b100);
        chk($sformatf("v%0d rsp fields", k),
            {rsp_id, rsp_rw, rsp_resp, rsp_rdata},
            {v.id, v.rw, v.exp_resp, v.exp_rdata});
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk($sformatf("v%0d rsp drop", k), rsp_valid, 0);
    endtask

    initial begin
        vec_t r;
        int   n;
        logic [42:0] snap;
        vecs[0] = '{0, 32'hFFFF_0000, 32'h0000_1000, 4'd3, 32'h0, 4'd0, 1'b0,
                    0, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b00, 32'hDEAD_BEEF};
        vecs[1] = '{1, 32'h0000_0040, 32'h0000_0999, 4'd5, 32'h1234_5678, 4'd5,
                    1'b1, 2, 32'h0000_AAAA, 1'b0, 1'b1, 2'b00, 32'h0};
        vecs[2] = '{1, 32'h0000_0080, 32'h0, 4'd2, 32'h1111_1111, 4'd7, 1'b1,
                    0, 32'h0, 1'b0, 1'b0, 2'b10, 32'h0};
        vecs[3] = '{1, 32'h0000_0084, 32'h0, 4'd4, 32'h2222_2222, 4'd4, 1'b0,
                    0, 32'h0, 1'b0, 1'b0, 2'b10, 32'h0};
        vecs[4] = '{0, 32'h0, 32'h0000_2000, 4'd9, 32'h0, 4'd0, 1'b0,
                    1, 32'h5555_5555, 1'b1, 1'b1, 2'b10, 32'h0};
        vecs[5] = '{0, 32'h0, 32'hABCD_0004, 4'd15, 32'h0, 4'd0, 1'b0,
                    3, 32'h0BAD_F00D, 1'b0, 1'b1, 2'b00, 32'h0BAD_F00D};
        vecs[6] = '{1, 32'hFFFF_FFFC, 32'h0, 4'd0, 32'hFFFF_FFFF, 4'd0, 1'b1,
                    0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0};

        idle_inputs();
        rst = 1;
        step();
        step();
        chk("reset outputs",
            {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_id,
             rsp_rw, rsp_rdata, rsp_resp}, 0);
        rst = 0;
        step();

        for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

        // Read with no PREADY: exactly 16 ACCESS cycles then SLVERR.
        r = vecs[0];
        drive_req(r);
        step();
        idle_inputs();
        step();
        n = 0;
        while (psel && penable && n < 40) begin
            n++;
            step();
        end
        chk("timeout access cycles", n, 16);
        chk("timeout rsp", {rsp_valid, psel, rsp_resp, rsp_rdata},
            {1'b1, 1'b0, 2'b10, 32'h0});
        rsp_ready = 1;
        step();
        rsp_ready = 0;

        // Write held off by missing write data, then response backpressure.
        r = vecs[1];
        drive_req(r);
        wdat_valid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("wait data %0d", i),
                {addr_ready, wdat_ready, psel}, 3'b000);
            step();
        end
        wdat_valid = 1;
        #1;
        chk("data arrives pop", {addr_ready, wdat_ready}, 2'b11);
        step();
        idle_inputs();
        step();
        pready = 1;
        step();
        pready = 0;
        chk("bp rsp valid", rsp_valid, 1);
        snap = {rsp_id, rsp_rw, rsp_resp, rsp_rdata, rsp_valid, psel, penable,
                1'b0};
        r = vecs[0];
        drive_req(r);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("bp hold %0d", i),
                {rsp_id, rsp_rw, rsp_resp, rsp_rdata, rsp_valid, psel, penable,
                 addr_ready}, snap);
            step();
        end
        idle_inputs();
        chk("bp rsp fields", {rsp_id, rsp_rw, rsp_resp, rsp_rdata},
            {4'd5, 1'b1, 2'b00, 32'h0});
        rsp_ready = 1;
        step();
        rsp_ready = 0;

        // Reset during ACCESS drops the transfer; next read is normal.
        r = vecs[5];
        drive_req(r);
        step();
        idle_inputs();
        step();
        chk("pre-reset access", {psel, penable}, 2'b11);
        rst = 1;
        step();
        rst = 0;
        chk("mid reset", {psel, penable, rsp_valid}, 3'b000);
        run_vec(10, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
